// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - SRAM-like inst/data request responder issuing single-beat AXI transactions
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        own_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        accept_data;
    logic        accept_inst;
    logic        aw_ok;
    logic        w_ok;

    assign accept_data = (state == S_IDLE) && data_req;
    assign accept_inst = (state == S_IDLE) && inst_req && !data_req;

    // A channel counts as done if it completed earlier or is completing now.
    assign aw_ok = aw_done_q || (awvalid && awready);
    assign w_ok  = w_done_q  || (wvalid && wready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_data) begin
                    state_nxt = data_wr ? S_AW_W : S_AR;
                end else if (accept_inst) begin
                    state_nxt = S_AR;
                end
            end
            S_AR:    if (arready) state_nxt = S_R;
            S_R:     if (rvalid) state_nxt = S_IDLE;
            S_AW_W:  if (aw_ok && w_ok) state_nxt = S_B;
            S_B:     if (bvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        data_addr_ok = accept_data;
        inst_addr_ok = accept_inst;
        arvalid      = (state == S_AR);
        rready       = (state == S_R);
        awvalid      = (state == S_AW_W) && !aw_done_q;
        wvalid       = (state == S_AW_W) && !w_done_q;
        bready       = (state == S_B);
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid   = {3'b000, own_q};
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept_data) begin
            own_q   <= 1'b1;
            wr_q    <= data_wr;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
        end else if (accept_inst) begin
            own_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd2;
            addr_q  <= inst_addr;
            wdata_q <= 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state != S_AW_W) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done_q <= 1'b1;
            if (wvalid && wready)   w_done_q  <= 1'b1;
        end
    end

    // Response pulses and read data are registered so the core sees them the cycle after the handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= 32'd0;
            data_rdata   <= 32'd0;
        end else begin
            inst_data_ok <= (state == S_R) && rvalid && !own_q;
            data_data_ok <= ((state == S_R) && rvalid && own_q) || ((state == S_B) && bvalid);
            if ((state == S_R) && rvalid) begin
                if (own_q) data_rdata <= rdata;
                else       inst_rdata <= rdata;
            end
        end
    end

    wire unused_ok = wr_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - self-checking bench for sram_axi_bridge with transaction model and AXI slave
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int errors = 0;
    int checks = 0;

    // slave configuration and state
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [31:0] rd_val = 32'd0;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit rd_pend, aw_got, w_got, b_pend;

    // transaction-level model of the bridge
    bit          m_busy, m_own, m_wr, m_ar, m_aw, m_w;
    bit          m_inst_ok, m_data_ok, m_accepted;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_inst_rd, m_data_rd;

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_strb(logic [1:0] sz, logic [31:0] a);
        case (sz)
            2'd0:    return 4'b0001 << (a % 4);
            2'd1:    return 4'b0011 << (a & 32'd2);
            default: return 4'b1111;
        endcase
    endfunction

    task automatic slave_clear();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    endtask

    task automatic model_clear();
        m_busy = 0; m_own = 0; m_wr = 0; m_ar = 0; m_aw = 0; m_w = 0;
        m_inst_ok = 0; m_data_ok = 0; m_accepted = 0;
        m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
        m_inst_rd = 32'd0; m_data_rd = 32'd0;
    endtask

    // One clock cycle: drive slave, compare against model, advance model and slave. Entered and left at negedge.
    task automatic tick();
        bit e_dok, e_iok, e_arv, e_rr, e_awv, e_wv, e_br;
        arready = arvalid && (ar_cnt >= ar_lat);
        rvalid  = rd_pend && (r_cnt >= r_lat);
        rdata   = rvalid ? rd_val : 32'hDEADBEEF;
        awready = awvalid && (aw_cnt >= aw_lat);
        wready  = wvalid && (w_cnt >= w_lat);
        bvalid  = b_pend && (b_cnt >= b_lat);
        #1;
        e_dok = !m_busy && data_req;
        e_iok = !m_busy && inst_req && !data_req;
        e_arv = m_busy && !m_wr && !m_ar;
        e_rr  = m_busy && !m_wr && m_ar;
        e_awv = m_busy && m_wr && !m_aw;
        e_wv  = m_busy && m_wr && !m_w;
        e_br  = m_busy && m_wr && m_aw && m_w;
        chk1("data_addr_ok", data_addr_ok, e_dok);
        chk1("inst_addr_ok", inst_addr_ok, e_iok);
        chk1("arvalid", arvalid, e_arv);
        chk1("rready", rready, e_rr);
        chk1("awvalid", awvalid, e_awv);
        chk1("wvalid", wvalid, e_wv);
        chk1("bready", bready, e_br);
        chk1("inst_data_ok", inst_data_ok, m_inst_ok);
        chk1("data_data_ok", data_data_ok, m_data_ok);
        chk32("inst_rdata", inst_rdata, m_inst_rd);
        chk32("data_rdata", data_rdata, m_data_rd);
        if (e_arv) begin
            chk32("araddr", araddr, m_addr);
            chk32("arid", 32'(arid), 32'(m_own));
            chk32("arsize", 32'(arsize), 32'(m_size));
        end
        if (e_awv) begin
            chk32("awaddr", awaddr, m_addr);
            chk32("awsize", 32'(awsize), 32'(m_size));
        end
        if (e_wv) begin
            chk32("wdata", wdata, m_wdata);
            chk32("wstrb", 32'(wstrb), 32'(exp_strb(m_size, m_addr)));
        end

        m_inst_ok = 0; m_data_ok = 0; m_accepted = 0;
        if (m_busy) begin
            if (!m_wr) begin
                if (e_arv && arready) begin
                    m_ar = 1;
                end else if (e_rr && rvalid) begin
                    if (m_own) begin m_data_ok = 1; m_data_rd = rd_val; end
                    else       begin m_inst_ok = 1; m_inst_rd = rd_val; end
                    m_busy = 0;
                end
            end else begin
                if (e_br && bvalid) begin
                    m_data_ok = 1;
                    m_busy = 0;
                end else begin
                    if (e_awv && awready) m_aw = 1;
                    if (e_wv && wready)   m_w = 1;
                end
            end
        end else if (e_dok || e_iok) begin
            m_busy = 1; m_accepted = 1; m_ar = 0; m_aw = 0; m_w = 0;
            if (e_dok) begin
                m_own = 1; m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
            end else begin
                m_own = 0; m_wr = 0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 32'd0;
            end
        end

        if (arvalid && arready) begin rd_pend = 1; r_cnt = 0; ar_cnt = 0; end
        else if (arvalid) ar_cnt++;
        if (rvalid && rready) rd_pend = 0;
        else if (rd_pend) r_cnt++;
        if (bvalid && bready) b_pend = 0;
        else if (b_pend) b_cnt++;
        if (awvalid && awready) begin aw_got = 1; aw_cnt = 0; end
        else if (awvalid) aw_cnt++;
        if (wvalid && wready) begin w_got = 1; w_cnt = 0; end
        else if (wvalid) w_cnt++;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        chk32("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk32("reset_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk32("reset_inst_rdata", inst_rdata, 32'd0);
        chk32("reset_data_rdata", data_rdata, 32'd0);
        chk32("reset_arid", 32'(arid), 32'd0);
        chk32("reset_araddr", araddr, 32'd0);
        chk32("reset_awaddr", awaddr, 32'd0);
        slave_clear();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic issue_data(bit wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wd);
        data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_accepted) break;
        end
        chk1("issue_data_accepted", m_accepted, 1'b1);
        data_req = 1'b0;
    endtask

    task automatic issue_inst(logic [31:0] addr);
        inst_req = 1'b1; inst_addr = addr;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_accepted) break;
        end
        chk1("issue_inst_accepted", m_accepted, 1'b1);
        inst_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (!m_busy && !m_inst_ok && !m_data_ok) break;
            tick();
        end
        chk1("drain_completed", m_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b1;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        slave_clear();
        model_clear();
        @(negedge clk);
        apply_reset();

        // data wins over inst when both request together
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        rd_val = 32'h1122_3344;
        #1;
        chk1("t1_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t1_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0; inst_req = 1'b0;
        chk1("t1_arvalid", arvalid, 1'b1);
        chk32("t1_arid", 32'(arid), 32'd1);
        chk32("t1_araddr", araddr, 32'h0000_1000);
        drain();
        chk32("t1_data_rdata", data_rdata, 32'h1122_3344);

        // zero-wait instruction fetch: data_ok in cycle 3 only
        rd_val = 32'h3C08_0001;
        issue_inst(32'hBFC0_0000);
        tick();
        chk1("t2_ok_cycle2", inst_data_ok, 1'b0);
        tick();
        chk1("t2_ok_cycle3", inst_data_ok, 1'b1);
        chk32("t2_inst_rdata", inst_rdata, 32'h3C08_0001);
        tick();
        chk1("t2_ok_cycle4", inst_data_ok, 1'b0);

        // byte store to the top lane
        issue_data(1'b1, 2'd0, 32'h0000_2003, 32'hAB00_0000);
        chk32("t3_wstrb", 32'(wstrb), 32'h8);
        chk32("t3_awsize", 32'(awsize), 32'd0);
        tick();
        chk1("t3_ok_cycle2", data_data_ok, 1'b0);
        tick();
        chk1("t3_ok_cycle3", data_data_ok, 1'b1);
        tick();
        chk1("t3_ok_cycle4", data_data_ok, 1'b0);

        // halfword store, wready three cycles after awready
        w_lat = 3;
        issue_data(1'b1, 2'd1, 32'h0000_2002, 32'hCDEF_0000);
        chk32("t4_wstrb", 32'(wstrb), 32'hC);
        tick();
        chk1("t4_awvalid_dropped", awvalid, 1'b0);
        chk1("t4_wvalid_held", wvalid, 1'b1);
        chk1("t4_bready_c2", bready, 1'b0);
        tick();
        tick();
        chk1("t4_bready_c4", bready, 1'b0);
        tick();
        chk1("t4_bready_c5", bready, 1'b1);
        chk1("t4_wvalid_c5", wvalid, 1'b0);
        drain();
        w_lat = 0;

        // back-to-back loads with data_req held through data_ok
        rd_val = 32'hA5A5_0001;
        issue_data(1'b0, 2'd2, 32'h0000_3000, 32'd0);
        data_req = 1'b1; data_addr = 32'h0000_3004;
        tick();
        tick();
        rd_val = 32'hA5A5_0002;
        #1;
        chk1("t5_data_ok", data_data_ok, 1'b1);
        chk1("t5_addr_ok_same_cycle", data_addr_ok, 1'b1);
        chk32("t5_first_rdata", data_rdata, 32'hA5A5_0001);
        tick();
        data_req = 1'b0;
        drain();
        chk32("t5_second_rdata", data_rdata, 32'hA5A5_0002);

        // size 3 store and a slow-slave fetch
        issue_data(1'b1, 2'd3, 32'h0000_4001, 32'h1234_5678);
        drain();
        ar_lat = 2; r_lat = 1; b_lat = 2;
        rd_val = 32'hCAFE_F00D;
        issue_inst(32'h0000_0100);
        drain();
        chk32("t6_inst_rdata", inst_rdata, 32'hCAFE_F00D);
        issue_data(1'b1, 2'd2, 32'h0000_4004, 32'h0BAD_F00D);
        drain();
        ar_lat = 0; r_lat = 3; b_lat = 0;

        // reset while in R with rvalid pending
        rd_val = 32'h9999_9999;
        issue_data(1'b0, 2'd2, 32'h0000_5000, 32'd0);
        tick();
        chk1("t7_in_r", rready, 1'b1);
        rvalid = 1'b1; rdata = rd_val;
        apply_reset();
        r_lat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t7_no_data_ok", data_data_ok, 1'b0);
        end

        rd_val = 32'h7777_0001;
        issue_data(1'b0, 2'd2, 32'h0000_6000, 32'd0);
        drain();
        chk32("t8_recovered_rdata", data_rdata, 32'h7777_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
